// File: rtl/branch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// branch_seq_ctrl
// Control-step sequencer for the conditional branch instructions
// (brzr/brnz/brpl/brmi) of a single-bus datapath. It walks through instruction
// fetch (T0..T2) and condition evaluation through the CON flip-flop (T3, T4).
// When the condition holds, it also computes the target and loads PC (T4..T6).
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   start                 begin one instruction (only looked at in IDLE)
//   abort                 synchronous abort, returns to IDLE on the next edge
//   ir[31:0]              IR contents; opcode ir[31:27] is checked in T3
//   mem_rdy               instruction memory read data valid
//   con_q                 CON flip-flop output
//   pc_out..pc_in         datapath strobes, one step group per cycle
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse at instruction completion
//   taken                 CON result latched at the end of T4
//   err[1:0]              00 none, 01 illegal opcode, 10 memory timeout
//   dbg_state[3:0]        current sequencer state, for observation only
//
// Handshake: memory read data is accepted in a T1 cycle when mem_rdy is high.
// mem_rd stays high for every T1 cycle, and mdr_in follows mem_rdy in that
// same cycle. abort has priority over every other transition.
// -----------------------------------------------------------------------------
module branch_seq_ctrl #(
   parameter logic [4:0] BR_OPCODE   = 5'b10010,
   parameter int         MEM_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [31:0] ir,
   input  logic        mem_rdy,
   input  logic        con_q,
   output logic        pc_out,
   output logic        mar_in,
   output logic        inc_pc,
   output logic        mem_rd,
   output logic        mdr_in,
   output logic        mdr_out,
   output logic        ir_in,
   output logic        gra,
   output logic        r_out,
   output logic        con_in,
   output logic        y_in,
   output logic        c_out,
   output logic        alu_add,
   output logic        z_in,
   output logic        zlo_out,
   output logic        pc_in,
   output logic        busy,
   output logic        done,
   output logic        taken,
   output logic [1:0]  err,
   output logic [3:0]  dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_DONE = 4'd8
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state, state_nxt;
   logic [7:0] cnt, cnt_nxt;
   logic       taken_nxt;
   logic [1:0] err_nxt;

   // The remaining IR fields (condition code, Ra) go to the CON logic and
   // the register file directly. Only the opcode is decoded here.
   logic unused_ir;
   assign unused_ir = ^ir[26:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
         taken <= 1'b0;
         err   <= 2'b00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         taken <= taken_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      taken_nxt = taken;
      err_nxt   = err;
      if (abort) begin
         // Abort freezes err and taken so that the last reported status survives.
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               state_nxt = S_T0;
               err_nxt   = 2'b00;
               taken_nxt = 1'b0;
            end
            S_T0: begin
               state_nxt = S_T1;
               cnt_nxt   = 8'd0;
            end
            S_T1: begin
               if (mem_rdy) begin
                  state_nxt = S_T2;
               end else if (cnt == CNT_LAST) begin
                  // This is the MEM_TIMEOUT-th T1 cycle without data, so give up.
                  state_nxt = S_IDLE;
                  err_nxt   = 2'b10;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
            S_T2: state_nxt = S_T3;
            S_T3: begin
               if (ir[31:27] != BR_OPCODE) begin
                  state_nxt = S_IDLE;
                  err_nxt   = 2'b01;
               end else begin
                  state_nxt = S_T4;
               end
            end
            S_T4: begin
               // CON was latched by con_in in T3, so con_q is settled here.
               taken_nxt = con_q;
               state_nxt = con_q ? S_T5 : S_DONE;
            end
            S_T5:    state_nxt = S_T6;
            S_T6:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      pc_out  = 1'b0;
      mar_in  = 1'b0;
      inc_pc  = 1'b0;
      mem_rd  = 1'b0;
      mdr_in  = 1'b0;
      mdr_out = 1'b0;
      ir_in   = 1'b0;
      gra     = 1'b0;
      r_out   = 1'b0;
      con_in  = 1'b0;
      y_in    = 1'b0;
      c_out   = 1'b0;
      alu_add = 1'b0;
      z_in    = 1'b0;
      zlo_out = 1'b0;
      pc_in   = 1'b0;
      done    = 1'b0;
      case (state)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
         end
         S_T1: begin
            mem_rd = 1'b1;
            mdr_in = mem_rdy;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_T3: if (ir[31:27] == BR_OPCODE) begin
            gra    = 1'b1;
            r_out  = 1'b1;
            con_in = 1'b1;
         end
         S_T4: begin
            // PC is moved into Y only when the branch will actually be taken.
            pc_out = con_q;
            y_in   = con_q;
         end
         S_T5: begin
            c_out   = 1'b1;
            alu_add = 1'b1;
            z_in    = 1'b1;
         end
         S_T6: begin
            zlo_out = 1'b1;
            pc_in   = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_seq_ctrl
// Bench for branch_seq_ctrl. Each instruction is described by its T1 wait,
// opcode, CON value and optional abort cycle. From that description a model
// builds the list of strobe groups that should appear cycle by cycle. Every
// cycle is compared against that list. A table of hand-computed outcomes
// (latency, err, taken) covers the named corner cases. Random instructions
// follow, and an asynchronous reset is applied mid-instruction.
// -----------------------------------------------------------------------------
module tb_branch_seq_ctrl;

  localparam logic [4:0] BR  = 5'b10010;
  localparam int         MEM_TIMEOUT = 15;

  // Observation vector layout, MSB first.
  localparam logic [20:0] M_PC_OUT  = 21'(1) << 20;
  localparam logic [20:0] M_MAR_IN  = 21'(1) << 19;
  localparam logic [20:0] M_INC_PC  = 21'(1) << 18;
  localparam logic [20:0] M_MEM_RD  = 21'(1) << 17;
  localparam logic [20:0] M_MDR_IN  = 21'(1) << 16;
  localparam logic [20:0] M_MDR_OUT = 21'(1) << 15;
  localparam logic [20:0] M_IR_IN   = 21'(1) << 14;
  localparam logic [20:0] M_GRA     = 21'(1) << 13;
  localparam logic [20:0] M_R_OUT   = 21'(1) << 12;
  localparam logic [20:0] M_CON_IN  = 21'(1) << 11;
  localparam logic [20:0] M_Y_IN    = 21'(1) << 10;
  localparam logic [20:0] M_C_OUT   = 21'(1) << 9;
  localparam logic [20:0] M_ALU_ADD = 21'(1) << 8;
  localparam logic [20:0] M_Z_IN    = 21'(1) << 7;
  localparam logic [20:0] M_ZLO_OUT = 21'(1) << 6;
  localparam logic [20:0] M_PC_IN   = 21'(1) << 5;
  localparam logic [20:0] M_BUSY    = 21'(1) << 4;
  localparam logic [20:0] M_DONE    = 21'(1) << 3;
  localparam logic [20:0] M_TAKEN   = 21'(1) << 2;

  logic        clock, reset_n, start, abort, mem_rdy, con_q;
  logic [31:0] ir;
  logic        pc_out, mar_in, inc_pc, mem_rd, mdr_in, mdr_out, ir_in;
  logic        gra, r_out, con_in, y_in, c_out, alu_add, z_in, zlo_out, pc_in;
  logic        busy, done, taken;
  logic [1:0]  err;
  logic [3:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];

  typedef struct {
    int         w;
    logic [4:0] op;
    logic       con;
    int         ab;
    int         exp_cycles;
    logic [1:0] exp_err;
    logic       exp_taken;
  } vec_t;
  vec_t tbl[11];

  branch_seq_ctrl #(.BR_OPCODE(BR), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .ir(ir),
    .mem_rdy(mem_rdy), .con_q(con_q), .pc_out(pc_out), .mar_in(mar_in),
    .inc_pc(inc_pc), .mem_rd(mem_rd), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .ir_in(ir_in), .gra(gra), .r_out(r_out), .con_in(con_in), .y_in(y_in),
    .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlo_out(zlo_out),
    .pc_in(pc_in), .busy(busy), .done(done), .taken(taken), .err(err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [20:0] obs();
    return {pc_out, mar_in, inc_pc, mem_rd, mdr_in, mdr_out, ir_in, gra, r_out,
            con_in, y_in, c_out, alu_add, z_in, zlo_out, pc_in, busy, done,
            taken, err};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %06h expected %06h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference model: the strobe group of each control step, in order.
  task automatic build_exp(input int w, input logic [4:0] op, input logic con, input int ab);
    logic [1:0]  err_o;
    logic        taken_o;
    logic [20:0] idle_v;
    exp_q.delete();
    err_o = 2'b00;
    exp_q.push_back(M_PC_OUT | M_MAR_IN | M_INC_PC | M_BUSY);
    if (w >= MEM_TIMEOUT) begin
      repeat (MEM_TIMEOUT) exp_q.push_back(M_MEM_RD | M_BUSY);
      err_o = 2'b10;
    end else begin
      repeat (w) exp_q.push_back(M_MEM_RD | M_BUSY);
      exp_q.push_back(M_MEM_RD | M_MDR_IN | M_BUSY);
      exp_q.push_back(M_MDR_OUT | M_IR_IN | M_BUSY);
      if (op != BR) begin
        exp_q.push_back(M_BUSY);
        err_o = 2'b01;
      end else begin
        exp_q.push_back(M_GRA | M_R_OUT | M_CON_IN | M_BUSY);
        if (con) begin
          exp_q.push_back(M_PC_OUT | M_Y_IN | M_BUSY);
          exp_q.push_back(M_C_OUT | M_ALU_ADD | M_Z_IN | M_BUSY | M_TAKEN);
          exp_q.push_back(M_ZLO_OUT | M_PC_IN | M_BUSY | M_TAKEN);
          exp_q.push_back(M_DONE | M_BUSY | M_TAKEN);
        end else begin
          exp_q.push_back(M_BUSY);
          exp_q.push_back(M_DONE | M_BUSY);
        end
      end
    end
    // An abort ends the instruction after the cycle it is seen in. No error
    // is reported, and taken keeps whatever it had reached by then.
    if (ab >= 0 && ab < exp_q.size()) begin
      while (exp_q.size() > ab + 1) exp_q.delete(exp_q.size() - 1);
      err_o = 2'b00;
    end
    taken_o = exp_q[exp_q.size() - 1][2];
    idle_v = '0;
    idle_v[2] = taken_o;
    idle_v[1:0] = err_o;
    exp_q.push_back(idle_v);
  endtask

  // driver: one instruction, compared cycle by cycle, ending with one idle cycle
  task automatic run_txn(input int w, input logic [4:0] op, input logic con, input int ab,
                         output int busy_n, output int done_n,
                         output logic [1:0] err_f, output logic taken_f);
    int n, t1_end;
    logic [20:0] got, exp;
    build_exp(w, op, con, ab);
    n = exp_q.size();
    t1_end = (w < MEM_TIMEOUT) ? 1 + w : MEM_TIMEOUT;
    busy_n = 0;
    done_n = 0;
    err_f = 2'b00;
    taken_f = 1'b0;
    ir = {op, 27'($urandom)};
    con_q = con;
    @(posedge clock); #1;
    start = 1'b1;
    abort = 1'b0;
    mem_rdy = 1'($urandom);
    for (int idx = 0; idx < n; idx++) begin
      @(posedge clock); #1;
      start = (idx == n - 1) ? 1'b0 : 1'($urandom);
      abort = (idx == ab);
      if (idx >= 1 && idx <= t1_end) mem_rdy = (w < MEM_TIMEOUT) && (idx == t1_end);
      else mem_rdy = 1'($urandom);
      @(negedge clock);
      got = obs();
      exp = exp_q.pop_front();
      check($sformatf("cycle%0d_w%0d_op%0h_con%0d_ab%0d", idx, w, op, con, ab), got, exp);
      busy_n += int'(got[4]);
      done_n += int'(got[3]);
      err_f = got[1:0];
      taken_f = got[2];
    end
    abort = 1'b0;
  endtask

  initial begin
    int busy_n, done_n, w, ab;
    logic [1:0] err_f;
    logic taken_f;
    logic [4:0] op;

    tbl[0]  = '{2,  BR,       1'b1, -1, 10, 2'b00, 1'b1};
    tbl[1]  = '{2,  BR,       1'b0, -1,  8, 2'b00, 1'b0};
    tbl[2]  = '{0,  5'b00000, 1'b1, -1,  4, 2'b01, 1'b0};
    tbl[3]  = '{0,  BR,       1'b1, -1,  8, 2'b00, 1'b1};
    tbl[4]  = '{20, BR,       1'b1, -1, 16, 2'b10, 1'b0};
    tbl[5]  = '{1,  BR,       1'b1,  2,  3, 2'b00, 1'b0};
    tbl[6]  = '{14, BR,       1'b0, -1, 20, 2'b00, 1'b0};
    tbl[7]  = '{0,  BR,       1'b1,  4,  5, 2'b00, 1'b0};
    tbl[8]  = '{0,  BR,       1'b1,  5,  6, 2'b00, 1'b1};
    tbl[9]  = '{15, BR,       1'b0, -1, 16, 2'b10, 1'b0};
    tbl[10] = '{3,  5'b10011, 1'b1, -1,  7, 2'b01, 1'b0};

    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mem_rdy = 1'b0;
    con_q = 1'b0;
    ir = '0;
    repeat (2) @(negedge clock);
    check("reset_state", obs(), 21'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_after_reset", obs(), 21'd0);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].w, tbl[i].op, tbl[i].con, tbl[i].ab, busy_n, done_n, err_f, taken_f);
      check_int($sformatf("tbl%0d_cycles", i), busy_n, tbl[i].exp_cycles);
      check_int($sformatf("tbl%0d_done", i), done_n,
                (tbl[i].exp_err == 2'b00 && tbl[i].ab < 0) ? 1 : 0);
      check_int($sformatf("tbl%0d_err", i), int'(err_f), int'(tbl[i].exp_err));
      check_int($sformatf("tbl%0d_taken", i), int'(taken_f), int'(tbl[i].exp_taken));
    end

    // Asynchronous reset in the middle of T5 of a taken branch.
    ir = {BR, 27'd0};
    con_q = 1'b1;
    @(posedge clock); #1;
    start = 1'b1;
    for (int idx = 0; idx <= 5; idx++) begin
      @(posedge clock); #1;
      start = 1'b0;
      mem_rdy = (idx == 1);
    end
    #1;
    check("pre_reset_t5", obs(), M_C_OUT | M_ALU_ADD | M_Z_IN | M_BUSY | M_TAKEN);
    reset_n = 1'b0;
    #1;
    check("async_reset_t5", obs(), 21'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check($sformatf("post_reset_idle%0d", k), obs(), 21'd0);
    end

    // random instructions against the model
    for (int i = 0; i < 40; i++) begin
      w = $urandom_range(0, 17);
      op = ($urandom_range(0, 3) != 0) ? BR : 5'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : -1;
      run_txn(w, op, 1'($urandom), ab, busy_n, done_n, err_f, taken_f);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
